// File: rtl/lfsr_prbs_gen_pkg.sv
// Shared LFSR definitions: FSM state type, default tap masks and a generic
// next-state helper for widths up to LFSR_MAX_W bits.
package lfsr_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} lfsr_state_e;

    localparam int LFSR_MAX_W = 64;

    localparam logic [3:0]  LFSR_TAPS_4  = 4'b1001;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // State bits above 'width' are ignored; the result is confined to 'width' bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width,
        input logic                  galois
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] s;
        mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
        s    = state & mask;
        if (galois) begin
            return ({1'b0, s[LFSR_MAX_W-1:1]} ^ (s[0] ? (taps & mask) : '0)) & mask;
        end
        return {s[LFSR_MAX_W-2:0], ^(s & taps)} & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Pure combinational LFSR next-state function, shared with the scrambler.
// Fibonacci shifts left with XOR feedback into bit 0; Galois shifts right and
// folds the tap mask in when the outgoing bit is set.
module lfsr_core #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter bit               GALOIS = 1'b0
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    generate
        if (GALOIS) begin : g_galois
            assign next_o = {1'b0, state_i[WIDTH-1:1]} ^ (state_i[0] ? TAPS : '0);
        end else begin : g_fib
            assign next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Back-pressurable PRBS word source: LFSR state, reference seed for period-wrap
// detection, step counter, IDLE/RUN handshake FSM and wrap/lock-up pulses.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED   = 16'h0001,
    parameter bit               GALOIS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_val;
    logic             seed_zero;
    logic             advance;

    lfsr_core #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_core (
        .state_i (state_q),
        .next_o  (next_state)
    );

    assign seed_zero = (seed_i == '0);
    assign load_val  = seed_zero ? SEED : seed_i;
    assign advance   = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        fsm_d   = ST_RUN;
        wrap_d  = 1'b0;
        lock_d  = 1'b0;
        if (seed_load_i) begin
            // A load discards any coincident handshake and drops valid for one cycle.
            state_d = load_val;
            ref_d   = load_val;
            cnt_d   = '0;
            fsm_d   = ST_IDLE;
            lock_d  = seed_zero;
        end else if (fsm_q == ST_RUN && state_q == '0) begin
            state_d = SEED;
            cnt_d   = '0;
            lock_d  = 1'b1;
        end else if (advance) begin
            state_d = next_state;
            if (next_state == ref_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            state_q <= SEED;
            ref_q   <= SEED;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    assign lfsr_o     = state_q;
    assign valid_o    = (fsm_q == ST_RUN);
    assign step_cnt_o = cnt_q;
    assign wrap_o     = wrap_q;
    assign lockup_o   = lock_q;

endmodule
